// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - layer-level sequencer for the conv datapath, bias and weight memories
module conv_layer_sequencer #(
  parameter int GRP_W        = 8,
  parameter int TILE_W       = 8,
  parameter int PIX_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [GRP_W-1:0]  cfg_oc_groups,
  input  logic [TILE_W-1:0] cfg_ic_tiles,
  input  logic [PIX_W-1:0]  cfg_pix_num,
  input  logic              bias_load_done,
  input  logic              wgt_load_done,
  input  logic              data_valid_in,
  output logic              bias_load_req,
  output logic              wgt_load_req,
  output logic              compute_en,
  output logic              acc_clear,
  output logic              acc_last,
  output logic [GRP_W-1:0]  group_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic [2:0]        current_state,
  output logic              state_rst,
  output logic              busy,
  output logic              done,
  output logic              stray_beat
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_W  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [GRP_W-1:0]  groups_q;
  logic [TILE_W-1:0] tiles_q;
  logic [PIX_W-1:0]  pix_q;
  logic [PIX_W-1:0]  pix_cnt;
  logic [DW-1:0]     drain_cnt;
  logic              state_rst_q;
  logic              accept;
  logic              next_tile;
  logic              next_group;
  logic              last_tile;

  assign last_tile = (tile_idx == tiles_q - TILE_W'(1));

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    next_tile  = 1'b0;
    next_group = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            accept = 1'b1;
            // A zero-sized layer has nothing to load; report completion straight away
            if (cfg_oc_groups == '0 || cfg_ic_tiles == '0 || cfg_pix_num == '0)
              state_d = S_DONE;
            else
              state_d = S_LOAD_B;
          end
        end
        S_LOAD_B:  if (bias_load_done) state_d = S_LOAD_W;
        S_LOAD_W:  if (wgt_load_done)  state_d = S_COMPUTE;
        S_COMPUTE: if (data_valid_in && pix_cnt == pix_q - PIX_W'(1)) state_d = S_DRAIN;
        S_DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            if (!last_tile) begin
              next_tile = 1'b1;
              state_d   = S_LOAD_W;
            end else if (group_idx != groups_q - GRP_W'(1)) begin
              next_group = 1'b1;
              state_d    = S_LOAD_B;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      state_rst_q <= 1'b0;
      groups_q    <= '0;
      tiles_q     <= '0;
      pix_q       <= '0;
      pix_cnt     <= '0;
      drain_cnt   <= '0;
      group_idx   <= '0;
      tile_idx    <= '0;
      stray_beat  <= 1'b0;
    end else begin
      state_q     <= state_d;
      state_rst_q <= (state_d != state_q);

      if (accept) begin
        groups_q  <= cfg_oc_groups;
        tiles_q   <= cfg_ic_tiles;
        pix_q     <= cfg_pix_num;
        group_idx <= '0;
        tile_idx  <= '0;
      end else if (next_tile) begin
        tile_idx <= tile_idx + TILE_W'(1);
      end else if (next_group) begin
        group_idx <= group_idx + GRP_W'(1);
        tile_idx  <= '0;
      end

      if (state_q != S_COMPUTE)  pix_cnt <= '0;
      else if (data_valid_in)    pix_cnt <= pix_cnt + PIX_W'(1);

      if (state_q != S_DRAIN) drain_cnt <= '0;
      else                    drain_cnt <= drain_cnt + DW'(1);

      // Beats outside COMPUTE are never counted, only flagged until the next run
      if (accept)                                    stray_beat <= 1'b0;
      else if (data_valid_in && state_q != S_COMPUTE) stray_beat <= 1'b1;
    end
  end

  assign current_state = state_q;
  assign state_rst     = state_rst_q;
  assign bias_load_req = (state_q == S_LOAD_B);
  assign wgt_load_req  = (state_q == S_LOAD_W);
  assign compute_en    = (state_q == S_COMPUTE);
  assign acc_clear     = (state_q == S_COMPUTE) && (tile_idx == '0);
  assign acc_last      = (state_q == S_COMPUTE || state_q == S_DRAIN) && last_tile;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - directed self-checking bench for conv_layer_sequencer
module tb_conv_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  cfg_oc_groups, cfg_ic_tiles;
  logic [15:0] cfg_pix_num;
  logic        bias_load_done, wgt_load_done, data_valid_in;
  logic        bias_load_req, wgt_load_req, compute_en, acc_clear, acc_last;
  logic [7:0]  group_idx, tile_idx;
  logic [2:0]  current_state;
  logic        state_rst, busy, done, stray_beat;
  logic        manual_valid, auto_valid;

  int nchk = 0, nerr = 0;
  int cyc, nb, nw, ncomp, nclr, nlast, ndone, nidx, tiles_m;
  logic prev_b, prev_w;

  always #5 clk = ~clk;

  // Auto mode streams one beat per cycle for as long as the sequencer computes
  assign data_valid_in = manual_valid | (auto_valid & (current_state == 3'd3));

  conv_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_oc_groups(cfg_oc_groups), .cfg_ic_tiles(cfg_ic_tiles), .cfg_pix_num(cfg_pix_num),
    .bias_load_done(bias_load_done), .wgt_load_done(wgt_load_done), .data_valid_in(data_valid_in),
    .bias_load_req(bias_load_req), .wgt_load_req(wgt_load_req), .compute_en(compute_en),
    .acc_clear(acc_clear), .acc_last(acc_last), .group_idx(group_idx), .tile_idx(tile_idx),
    .current_state(current_state), .state_rst(state_rst), .busy(busy), .done(done),
    .stray_beat(stray_beat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; nb = 0; nw = 0; ncomp = 0; nclr = 0; nlast = 0; ndone = 0; nidx = 0;
    prev_b = 1'b0; prev_w = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bias_load_req && !prev_b) nb++;
    if (wgt_load_req && !prev_w) nw++;
    prev_b = bias_load_req;
    prev_w = wgt_load_req;
    if (current_state == 3'd3) ncomp++;
    if (acc_clear) nclr++;
    if (acc_last) nlast++;
    if (done) ndone++;
    if ((current_state == 3'd3 || current_state == 3'd4) && nw > 0)
      if (int'(tile_idx) != (nw - 1) % tiles_m || int'(group_idx) != (nw - 1) / tiles_m) nidx++;
  endtask

  task automatic pulse_start(input int g, input int t, input int p);
    cfg_oc_groups = 8'(g); cfg_ic_tiles = 8'(t); cfg_pix_num = 16'(p);
    tiles_m = (t == 0) ? 1 : t;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin step(); n++; end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max);
    int n = 0;
    while (current_state != s && n < max) begin step(); n++; end
    if (current_state != s) check({tag, "_timeout"}, 0, 1);
  endtask

  logic [2:0] exp_seq [12];
  logic [2:0] prev_s;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; manual_valid = 1'b0; auto_valid = 1'b0;
    bias_load_done = 1'b0; wgt_load_done = 1'b0;
    cfg_oc_groups = '0; cfg_ic_tiles = '0; cfg_pix_num = '0; tiles_m = 1;
    clear_mon();
    step(); step();
    check("rst_state", current_state, 0);
    check("rst_outs", {bias_load_req, wgt_load_req, compute_en, acc_clear, acc_last,
                       state_rst, busy, done, stray_beat}, 0);
    check("rst_idx", {group_idx, tile_idx}, 0);
    rst = 1'b0;
    step();

    // 1x1x4 with immediate handshakes: cycle-by-cycle state walk
    bias_load_done = 1'b1; wgt_load_done = 1'b1; auto_valid = 1'b1;
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
    pulse_start(1, 1, 4);
    prev_s = 3'd0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t1_state%0d", i), current_state, exp_seq[i]);
      check($sformatf("t1_srst%0d", i), state_rst, (exp_seq[i] != prev_s));
      check($sformatf("t1_done%0d", i), done, (exp_seq[i] == 3'd5));
      prev_s = exp_seq[i];
      step();
    end

    // 2 groups x 3 tiles x 2 pixels: windows, accumulator control, indices
    clear_mon();
    pulse_start(2, 3, 2);
    wait_done("t2", 200);
    check("t2_cycles", cyc, 45);
    check("t2_bias_win", nb, 2);
    check("t2_wgt_win", nw, 6);
    check("t2_clr_cyc", nclr, 4);
    check("t2_last_cyc", nlast, 12);
    check("t2_idx_err", nidx, 0);
    step();
    check("t2_idle", current_state, 0);
    check("t2_group_hold", group_idx, 1);

    // zero-sized layer goes straight to DONE
    clear_mon();
    pulse_start(1, 1, 0);
    check("t3_state", current_state, 5);
    check("t3_done", done, 1);
    step();
    check("t3_idle", current_state, 0);
    check("t3_srst", state_rst, 1);
    check("t3_reqs", nb + nw, 0);

    // abort on the 2nd beat of group 1, then a clean restart
    clear_mon();
    pulse_start(2, 1, 2);
    begin
      int n = 0;
      while (!(current_state == 3'd3 && group_idx == 8'd1) && n < 100) begin step(); n++; end
      check("t4_reach_g1", group_idx, 1);
    end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_state", current_state, 0);
    check("t4_busy", busy, 0);
    check("t4_srst", state_rst, 1);
    check("t4_ndone", ndone, 0);
    check("t4_idx_hold", group_idx, 1);
    pulse_start(1, 1, 1);
    check("t4_restart_state", current_state, 1);
    check("t4_restart_idx", {group_idx, tile_idx}, 0);
    wait_done("t4", 50);
    step();

    // stray beat in LOAD_W is flagged, not counted
    bias_load_done = 1'b0; wgt_load_done = 1'b0;
    pulse_start(1, 1, 2);
    check("t5_state_lb", current_state, 1);
    bias_load_done = 1'b1;
    step();
    bias_load_done = 1'b0;
    manual_valid = 1'b1;
    step();
    manual_valid = 1'b0;
    check("t5_stray", stray_beat, 1);
    check("t5_state_lw", current_state, 2);
    clear_mon();
    wgt_load_done = 1'b1;
    wait_done("t5", 50);
    check("t5_compute_cyc", ncomp, 2);
    step();
    check("t5_stray_sticky", stray_beat, 1);
    pulse_start(1, 1, 0);
    check("t5_stray_clr", stray_beat, 0);
    step();

    // start while busy must not re-latch cfg
    bias_load_done = 1'b1; wgt_load_done = 1'b1;
    clear_mon();
    pulse_start(1, 1, 3);
    wait_state("t6", 3'd3, 20);
    cfg_pix_num = 16'd1; cfg_oc_groups = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t6", 100);
    check("t6_compute_cyc", ncomp, 3);
    check("t6_bias_win", nb, 1);
    check("t6_group", group_idx, 0);
    step();

    // reset mid-run returns everything to idle at once
    pulse_start(1, 1, 4);
    wait_state("t7", 3'd3, 20);
    rst = 1'b1;
    #1;
    check("t7_rst_state", current_state, 0);
    check("t7_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
